// File: rtl/vga_trace_packer_if.sv
// Record stream between the trace packer and its consumer.
`default_nettype none

interface vga_trace_packer_if #(
  parameter int REC_W = 33
);
  logic             m_valid;
  logic             m_ready;
  logic [REC_W-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/vga_trace_packer.sv
// Samples a bus for a programmed number of cycles and streams a header plus
// {run_len, sample} records, optionally run-length encoded, through a FIFO.
`default_nettype none

module vga_trace_packer #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 17,
  parameter int DEPTH    = 16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                start,
  input  wire logic [31:0]         total_cycles,
  input  wire logic                rle_en,
  input  wire logic [SAMPLE_W-1:0] sample_in,
  vga_trace_packer_if.master       m,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int REC_W = SAMPLE_W + CNT_W;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_MAX  = {CNT_W{1'b1}};
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  logic [2:0]          state, state_nxt;
  logic [31:0]         total_q;
  logic                rle_q;
  logic [31:0]         cnt;
  logic [SAMPLE_W-1:0] pend_sample;
  logic [CNT_W-1:0]    pend_len;

  logic [REC_W:0]      mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         level;

  logic                empty, full, pop, can_push, push_ok;
  logic                first, last_sample, emit_cond;
  logic                push_req, push_last;
  logic [REC_W-1:0]    push_data;
  logic [REC_W-1:0]    header;
  logic [REC_W:0]      head;

  assign empty       = (level == '0);
  assign full        = (level == FULL_LVL);
  assign pop         = !empty && m.m_ready;
  assign can_push    = !full || pop;
  assign push_ok     = push_req && can_push;
  assign first       = (cnt == 32'd0);
  assign last_sample = (cnt == total_q - 32'd1);
  assign emit_cond   = !first && (!rle_q || (sample_in != pend_sample) || (pend_len == LEN_MAX));

  always_comb begin
    header              = '0;
    header[REC_W-1]     = rle_q;
    header[31:0]        = total_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_HEADER;
      ST_HEADER:  state_nxt = (total_q == 32'd0) ? ST_DRAIN : ST_CAPTURE;
      ST_CAPTURE: if (last_sample) state_nxt = ST_FLUSH;
      ST_FLUSH:   if (can_push) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (empty) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: which record to push this cycle, plus status
  always_comb begin
    push_req  = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_HEADER: begin
        push_req  = 1'b1;
        push_data = header;
        push_last = (total_q == 32'd0);
      end
      ST_CAPTURE: begin
        push_req  = emit_cond;
        push_data = {pend_len, pend_sample};
      end
      ST_FLUSH: begin
        push_req  = 1'b1;
        push_data = {pend_len, pend_sample};
        push_last = 1'b1;
      end
      ST_DRAIN: done = empty;
      default: ;
    endcase
  end

  // Configuration, sample counter, pending run and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q     <= '0;
      rle_q       <= 1'b0;
      cnt         <= '0;
      pend_sample <= '0;
      pend_len    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        total_q  <= total_cycles;
        rle_q    <= rle_en;
        cnt      <= '0;
        overflow <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        cnt <= cnt + 32'd1;
        if (first || emit_cond) begin
          pend_sample <= sample_in;
          pend_len    <= LEN_ONE;
        end else begin
          pend_len <= pend_len + LEN_ONE;
        end
        if (push_req && !can_push) overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers; storage itself needs no reset since m_valid gates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_last, push_data};
  end

  assign head      = mem[rd_ptr];
  assign m.m_valid = !empty;
  assign m.m_data  = empty ? '0 : head[REC_W-1:0];
  assign m.m_last  = empty ? 1'b0 : head[REC_W];

endmodule

`default_nettype wire

// File: doc/vga_trace_packer.md
Name: vga_trace_packer

Overview:
- Synthesizable on-chip successor to the bench-side pin dumper.
- Samples a parametrised-width output bus, such as {uo_out, uio_out}, every clock for a programmed number of cycles.
- Packs each sample into a {run_length, sample} record, with optional run-length encoding (RLE) of identical consecutive samples.
- Streams a header record plus the data records through an internal FIFO on a valid/ready port. It sits beside the VGA core for in-system capture.

Parameters:
SAMPLE_W, 16, width of sampled bus
CNT_W, 17, run-length field width; SAMPLE_W+CNT_W must be >= 33
DEPTH, 16, FIFO depth in records (power of two, >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  capture start pulse; ignored while busy
total_cycles  in  32  number of samples to capture; latched on start
rle_en  in  1  1 = RLE mode, 0 = one record per cycle; latched on start
sample_in  in  SAMPLE_W  bus being traced
m_valid  out  1  record available
m_ready  in  1  consumer accepts record
m_data  out  SAMPLE_W+CNT_W  record = {run_len[CNT_W-1:0], sample[SAMPLE_W-1:0]}
m_last  out  1  marks final record of capture
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse at capture end
overflow  out  1  sticky: a record was dropped this capture

Behaviour:
- Reset (asynchronous, active-low) values: all outputs 0, FIFO empty, state IDLE, counters and latched configuration cleared. Reset mid-capture aborts the capture; no partial record survives.
- FSM states: IDLE -> HEADER -> CAPTURE -> FLUSH -> DRAIN -> IDLE.
- IDLE: on start=1, latch total_cycles and rle_en, clear overflow, go to HEADER. busy rises the next cycle.
- HEADER (1 cycle): push the header record.
  - Header fields: MSB = rle_en; low 32 bits = total_cycles; all other bits 0.
  - The FIFO is always empty here, so the header is never dropped.
  - Header m_last = 1 iff total_cycles==0; in that case go straight to DRAIN, otherwise go to CAPTURE.
- CAPTURE: sample_in is sampled every cycle; the first sample is taken in the first CAPTURE cycle.
  - Sample 0 loads the pending run with len=1.
  - For each later sample, emit the pending record and start a new run (len=1) if any of these hold: rle_en==0, sample differs from the pending sample, or pending len == 2^CNT_W-1.
  - Otherwise increment the pending len.
  - After total_cycles samples, go to FLUSH.
- FIFO push and drop rules (CAPTURE only):
  - A push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow is set to 1 (sticky until the next start).
  - Sampling never stalls.
- FLUSH: the pending run is pushed with m_last=1, waiting as many cycles as needed for space. It is never dropped. Then go to DRAIN.
- DRAIN: wait for the FIFO to empty, then pulse done=1 for one cycle, clear busy, go to IDLE.
- Output port:
  - m_data and m_last come from the FIFO head; m_valid = FIFO not empty.
  - A transfer occurs when m_valid & m_ready.
  - m_data and m_last are held stable while m_valid & !m_ready.
  - FIFO read latency is 0: the head is registered and visible the cycle after push.
- Counters: the 32-bit sample counter does not wrap; total_cycles up to 2^32-1 is supported.
- start while busy has no effect. start in the same cycle as done is accepted only after the return to IDLE (one cycle later).

Test Plan:
1. Non-RLE basic: rle_en=0, total_cycles=4, sample_in = 0x1111, 0x2222, 0x3333, 0x4444, m_ready=1 -> records in order:
   - header (low bits 0x00000004, MSB 0);
   - {1,0x1111}, {1,0x2222}, {1,0x3333};
   - {1,0x4444} with m_last=1;
   - then done pulse, overflow=0.
2. RLE basic: rle_en=1, total=10, sample 0xABCD for 6 cycles then 0x0001 for 4 -> header (MSB 1), {6,0xABCD}, {4,0x0001, last}.
3. Run saturation: CNT_W=4, SAMPLE_W=29, rle_en=1, total=20, constant 0x5 -> header, {15,0x5}, {5,0x5, last}.
4. Backpressure/overflow: rle_en=0, DEPTH=16, m_ready=0, total=40 -> FIFO fills to header + 15 records, 24 records dropped, overflow=1. Raise m_ready -> 16 records drain, then the final {1,sample39} with last; total of 17 transfers, then done.
5. Zero length: total=0 -> a single header with m_last=1, done pulse, no data records.
6. Reset mid-capture: assert rst_n=0 at sample 3 of 10 -> m_valid, busy, done, overflow all 0 immediately. A new start then produces a clean header with no stale records.
